loader_feeder: RTL and testbench

LOADER_FEEDER -- requirements
Module: loader_feeder

---
 rtl/loader_pkg.sv | 27 ++
 rtl/loader_feeder_if.sv | 28 ++
 rtl/loader_fifo.sv | 51 +++++
 rtl/loader_feeder.sv | 103 ++++++++++
 tb/tb_loader_feeder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared constants for the loader feeder: slot timing, phase codes and FSM encoding.
package loader_pkg;

  localparam int unsigned SLOT_LEN = 4;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_0    = 2'd0;
  localparam phase_t PH_1    = 2'd1;
  localparam phase_t PH_2    = 2'd2;
  localparam phase_t PH_3    = 2'd3;
  localparam phase_t PH_LAST = phase_t'(SLOT_LEN - 1);

  // Legacy encodings kept so existing decoders of the raw state bit stay valid.
  localparam logic [0:0] IDLE_ENC = 1'b0;
  localparam logic [0:0] SLOT_ENC = 1'b1;

  typedef enum logic [0:0] {
    IDLE = IDLE_ENC,
    SLOT = SLOT_ENC
  } state_t;

  function automatic int unsigned tile_width(input int unsigned nb_tiles);
    return (nb_tiles > 1) ? $clog2(nb_tiles) : 1;
  endfunction

endpackage

// File: rtl/loader_feeder_if.sv
// Host-side load handshake and mesh-side slot bus of the loader feeder.
interface loader_feeder_if #(
  parameter int unsigned ADDRESS_SIZE = 10,
  parameter int unsigned DATA_SIZE    = 8
);

  logic                    IN_VALID;
  logic [ADDRESS_SIZE-1:0] IN_ADDRESS;
  logic [DATA_SIZE-1:0]    IN_DATA;
  logic                    IN_READY;
  logic [ADDRESS_SIZE-1:0] ADDRESS;
  logic [DATA_SIZE-1:0]    DATA;
  logic                    SLOT_VALID;
  logic [1:0]              SLOT_PHASE;
  logic                    BUSY;
  logic                    ERR_RANGE;

  modport master (
    output IN_VALID, IN_ADDRESS, IN_DATA,
    input  IN_READY, ADDRESS, DATA, SLOT_VALID, SLOT_PHASE, BUSY, ERR_RANGE
  );

  modport slave (
    input  IN_VALID, IN_ADDRESS, IN_DATA,
    output IN_READY, ADDRESS, DATA, SLOT_VALID, SLOT_PHASE, BUSY, ERR_RANGE
  );

endinterface

// File: rtl/loader_fifo.sv
// Power-of-two FIFO with occupancy counter; pushes when full and pops when empty are dropped.
module loader_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_data = mem[rd_ptr];
  end

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/loader_feeder.sv
// Buffers host load words and replays each one on the mesh bus for a fixed 4-cycle slot.
module loader_feeder
  import loader_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = 10,
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned NB_TILES     = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic            CLK,
  input logic            RESET,
  loader_feeder_if.slave bus
);

  localparam int unsigned TW = tile_width(NB_TILES);
  localparam int unsigned WW = ADDRESS_SIZE + DATA_SIZE;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW:0] TILE_LIMIT = (TW + 1)'(NB_TILES);

  state_t                  state;
  phase_t                  phase;
  logic                    slot_valid;
  logic                    err_range;
  logic                    rst_done;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0]    data_q;

  logic                    push;
  logic                    pop;
  logic                    in_ready;
  logic                    out_of_range;
  logic [TW-1:0]           tile_idx;
  logic [WW-1:0]           fifo_rd;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;

  // IN_READY is held low through reset by rst_done, then tracks the registered full flag.
  always_comb begin
    in_ready     = rst_done && !fifo_full;
    push         = bus.IN_VALID && in_ready;
    pop          = !fifo_empty && ((state == IDLE) || (phase == PH_LAST));
    tile_idx     = bus.IN_ADDRESS[ADDRESS_SIZE-1 -: TW];
    out_of_range = ({1'b0, tile_idx} >= TILE_LIMIT);
  end

  loader_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (push),
    .pop     (pop),
    .wr_data ({bus.IN_ADDRESS, bus.IN_DATA}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A pop either starts the first slot from IDLE or chains the next slot at the last phase.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      phase      <= PH_0;
      slot_valid <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      err_range  <= 1'b0;
      rst_done   <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (push && out_of_range) err_range <= 1'b1;
      if (pop) begin
        state      <= SLOT;
        phase      <= PH_0;
        slot_valid <= 1'b1;
        addr_q     <= fifo_rd[WW-1 -: ADDRESS_SIZE];
        data_q     <= fifo_rd[DATA_SIZE-1:0];
      end else if (state == SLOT) begin
        if (phase == PH_LAST) begin
          state      <= IDLE;
          phase      <= PH_0;
          slot_valid <= 1'b0;
        end else begin
          phase <= phase + phase_t'(1);
        end
      end
    end
  end

  always_comb begin
    bus.IN_READY   = in_ready;
    bus.ADDRESS    = addr_q;
    bus.DATA       = data_q;
    bus.SLOT_VALID = slot_valid;
    bus.SLOT_PHASE = phase;
    bus.BUSY       = (fifo_count != '0) || (state == SLOT);
    bus.ERR_RANGE  = err_range;
  end

endmodule

// File: tb/tb_loader_feeder.sv
// Randomised scoreboard bench for loader_feeder, run with NB_TILES=3 so the range flag is reachable.
module tb_loader_feeder;

  localparam int unsigned AS = 10;
  localparam int unsigned DS = 8;
  localparam int unsigned NT = 3;
  localparam int unsigned FD = 4;

  typedef struct {
    logic [AS-1:0] a;
    logic [DS-1:0] d;
    int unsigned   acc;
    bit            bad;
  } item_t;

  logic        CLK   = 1'b0;
  logic        RESET = 1'b0;
  int unsigned cyc   = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  item_t         q[$];
  bit            m_valid = 1'b0;
  logic [1:0]    m_phase = 2'd0;
  logic [AS-1:0] m_addr  = '0;
  logic [DS-1:0] m_data  = '0;
  bit            m_err   = 1'b0;

  loader_feeder_if #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS)) bus ();

  loader_feeder #(
    .ADDRESS_SIZE (AS),
    .DATA_SIZE    (DS),
    .NB_TILES     (NT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s cycle %0d: wait bound expired", nm, cyc);
  endtask

  // Reference model: words leave the queue one per 4-cycle slot, earliest one cycle after acceptance.
  always @(negedge CLK) begin
    int unsigned occ;
    if (!RESET) begin
      chk("rst_valid", 32'(bus.SLOT_VALID), 32'd0);
      chk("rst_phase", 32'(bus.SLOT_PHASE), 32'd0);
      chk("rst_addr",  32'(bus.ADDRESS),    32'd0);
      chk("rst_data",  32'(bus.DATA),       32'd0);
      chk("rst_busy",  32'(bus.BUSY),       32'd0);
      chk("rst_ready", 32'(bus.IN_READY),   32'd0);
      chk("rst_err",   32'(bus.ERR_RANGE),  32'd0);
      q.delete();
      m_valid = 1'b0;
      m_phase = 2'd0;
      m_addr  = '0;
      m_data  = '0;
      m_err   = 1'b0;
    end else begin
      occ = 0;
      foreach (q[i]) begin
        if (q[i].acc <= cyc) begin
          occ++;
          if (q[i].bad) m_err = 1'b1;
        end
      end
      if (m_valid && m_phase != 2'd3) begin
        m_phase = m_phase + 2'd1;
      end else if (q.size() > 0 && q[0].acc < cyc) begin
        m_addr  = q[0].a;
        m_data  = q[0].d;
        void'(q.pop_front());
        occ--;
        m_valid = 1'b1;
        m_phase = 2'd0;
      end else begin
        m_valid = 1'b0;
        m_phase = 2'd0;
      end
      chk("slot_valid", 32'(bus.SLOT_VALID), 32'(m_valid));
      chk("slot_phase", 32'(bus.SLOT_PHASE), 32'(m_phase));
      chk("address",    32'(bus.ADDRESS),    32'(m_addr));
      chk("data",       32'(bus.DATA),       32'(m_data));
      chk("busy",       32'(bus.BUSY),       32'(m_valid || occ > 0));
      chk("in_ready",   32'(bus.IN_READY),   32'(occ < FD));
      chk("err_range",  32'(bus.ERR_RANGE),  32'(m_err));
    end
  end

  task automatic send(input logic [AS-1:0] a, input logic [DS-1:0] d);
    int unsigned waited = 0;
    bit done = 1'b0;
    bus.IN_VALID   = 1'b1;
    bus.IN_ADDRESS = a;
    bus.IN_DATA    = d;
    while (!done) begin
      @(negedge CLK);
      if (bus.IN_READY === 1'b1) begin
        q.push_back('{a: a, d: d, acc: cyc + 1, bad: (int'(a >> 8) >= NT)});
        done = 1'b1;
      end else if (++waited > 60) begin
        timeout("send_ready");
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int unsigned n);
    bus.IN_VALID = 1'b0;
    if (n > 0) begin
      repeat (n) @(posedge CLK);
      #1;
    end
  endtask

  task automatic drain();
    int unsigned waited = 0;
    bus.IN_VALID = 1'b0;
    while (q.size() > 0 || m_valid || bus.SLOT_VALID !== 1'b0) begin
      @(posedge CLK);
      #1;
      if (++waited > 300) begin
        timeout("drain");
        break;
      end
    end
    idle(2);
  endtask

  function automatic logic [AS-1:0] rand_addr();
    logic [1:0] t;
    t = 2'($urandom_range(0, NT - 1));
    return {t, 8'($urandom)};
  endfunction

  task automatic reset_mid_slot();
    int unsigned waited = 0;
    bit found = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_addr(), 8'($urandom));
    bus.IN_VALID = 1'b0;
    while (!found && waited < 20) begin
      @(negedge CLK);
      waited++;
      if (bus.SLOT_VALID === 1'b1 && bus.SLOT_PHASE === 2'd2) found = 1'b1;
    end
    if (!found) timeout("phase2_wait");
    #1 RESET = 1'b0;
    #1;
    chk("async_valid", 32'(bus.SLOT_VALID), 32'd0);
    chk("async_addr",  32'(bus.ADDRESS),    32'd0);
    chk("async_busy",  32'(bus.BUSY),       32'd0);
    chk("async_ready", 32'(bus.IN_READY),   32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;
    idle(20);
  endtask

  initial begin
    bus.IN_VALID   = 1'b0;
    bus.IN_ADDRESS = '0;
    bus.IN_DATA    = '0;
    repeat (3) @(negedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;

    send(10'h1A5, 8'h3C);
    drain();

    for (int i = 0; i < 3; i++) send(rand_addr(), 8'($urandom));
    drain();

    for (int i = 0; i < 6; i++) send(rand_addr(), 8'($urandom));
    drain();

    for (int i = 0; i < 10; i++) begin
      send(rand_addr(), 8'($urandom));
      idle(3);
    end
    drain();

    for (int i = 0; i < 40; i++) begin
      send(rand_addr(), 8'($urandom));
      idle($urandom_range(0, 5));
    end
    drain();

    reset_mid_slot();

    send(10'h3FF, 8'hA5);
    drain();
    chk("err_set", 32'(bus.ERR_RANGE), 32'd1);
    send(10'h012, 8'h34);
    send(10'h2FF, 8'h56);
    drain();
    chk("err_sticky", 32'(bus.ERR_RANGE), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
